// File: rtl/comp_driver_if.sv
// comp_driver_if
//   Bundles the element input stream, the packed score buses, the
//   comparison-layer load/valid pair and the result handshake.
//   modport master : the comp_driver side (consumes elements and cmp results,
//                    produces d1/d2/load and the result stream)
//   modport slave  : the surrounding environment (upstream layers, comparison
//                    layer and result consumer)
interface comp_driver_if #(
  parameter int DATA_LEN = 16,
  parameter int N_ELEM   = 12
);
  logic                       in_valid;
  logic                       in_sel;
  logic [DATA_LEN-1:0]        in_data;
  logic                       in_ready;
  logic [N_ELEM*DATA_LEN-1:0] d1;
  logic [N_ELEM*DATA_LEN-1:0] d2;
  logic                       load;
  logic                       cmp_valid;
  logic [3:0]                 cmp_q;
  logic                       res_valid;
  logic [3:0]                 res_class;
  logic                       res_ready;
  logic                       err;
  logic                       busy;

  modport master (
    input  in_valid, in_sel, in_data, cmp_valid, cmp_q, res_ready,
    output in_ready, d1, d2, load, res_valid, res_class, err, busy
  );

  modport slave (
    output in_valid, in_sel, in_data, cmp_valid, cmp_q, res_ready,
    input  in_ready, d1, d2, load, res_valid, res_class, err, busy
  );
endinterface

// File: rtl/comp_driver.sv
// comp_driver
//   Initiator side of the comparison-layer load/valid protocol. Two score
//   banks (d1, d2) are filled serially, one element per accepted cycle, in
//   any interleaving. Once both banks hold N_ELEM elements, load is raised
//   and held until the comparison layer pulses cmp_valid (or WAIT_MAX cycles
//   pass). The class index is then offered downstream on res_valid/res_ready,
//   after which one GAP cycle keeps load low before filling restarts.
// Ports
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : comp_driver_if.master
//          in_valid/in_sel/in_data/in_ready : element stream (in_ready comb.)
//          d1/d2      : packed banks, element i at [i*DATA_LEN +: DATA_LEN]
//          load       : level request to the comparison layer
//          cmp_valid/cmp_q : comparison result
//          res_valid/res_class/res_ready : result handshake (4'hF = timeout)
//          err        : sticky timeout flag, busy : not in FILL
module comp_driver #(
  parameter int DATA_LEN = 16,
  parameter int N_ELEM   = 12,
  parameter int WAIT_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  comp_driver_if.master bus
);

  localparam int CNT_W  = $clog2(N_ELEM + 1);
  localparam int IDX_W  = $clog2(N_ELEM);
  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(N_ELEM);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t                          state_r;
  logic [CNT_W-1:0]                cnt1_r;
  logic [CNT_W-1:0]                cnt2_r;
  logic [WAIT_W-1:0]               wait_r;
  logic [N_ELEM-1:0][DATA_LEN-1:0] d1_r;
  logic [N_ELEM-1:0][DATA_LEN-1:0] d2_r;
  logic                            load_r;
  logic                            res_valid_r;
  logic [3:0]                      res_class_r;
  logic                            err_r;
  logic                            busy_r;

  logic                            sel_room_s;
  logic                            in_ready_s;
  logic                            accept_s;
  logic [CNT_W-1:0]                cnt1_nxt_s;
  logic [CNT_W-1:0]                cnt2_nxt_s;
  logic                            both_full_s;

  // Accept decode: room check on the selected bank and next counter values.
  always_comb begin
    sel_room_s = 1'b0;
    cnt1_nxt_s = cnt1_r;
    cnt2_nxt_s = cnt2_r;
    if (bus.in_sel) begin
      sel_room_s = (cnt2_r < CNT_FULL);
    end else begin
      sel_room_s = (cnt1_r < CNT_FULL);
    end
    in_ready_s = (state_r == ST_FILL) && sel_room_s;
    accept_s   = in_ready_s && bus.in_valid;
    if (accept_s && bus.in_sel) begin
      cnt2_nxt_s = cnt2_r + CNT_ONE;
    end else if (accept_s) begin
      cnt1_nxt_s = cnt1_r + CNT_ONE;
    end else begin
      cnt1_nxt_s = cnt1_r;
      cnt2_nxt_s = cnt2_r;
    end
    // load must rise on the same edge that stores the last missing element.
    both_full_s = (cnt1_nxt_s == CNT_FULL) && (cnt2_nxt_s == CNT_FULL);
  end

  // Control FSM with bank storage and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_FILL;
      cnt1_r      <= '0;
      cnt2_r      <= '0;
      wait_r      <= '0;
      d1_r        <= '0;
      d2_r        <= '0;
      load_r      <= 1'b0;
      res_valid_r <= 1'b0;
      res_class_r <= 4'h0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_FILL: begin
          if (accept_s && bus.in_sel) begin
            d2_r[cnt2_r[IDX_W-1:0]] <= bus.in_data;
          end else if (accept_s) begin
            d1_r[cnt1_r[IDX_W-1:0]] <= bus.in_data;
          end
          cnt1_r <= cnt1_nxt_s;
          cnt2_r <= cnt2_nxt_s;
          if (both_full_s) begin
            state_r <= ST_RUN;
            load_r  <= 1'b1;
            busy_r  <= 1'b1;
            wait_r  <= '0;
          end
        end
        ST_RUN: begin
          // A real result wins over a timeout landing on the same cycle.
          if (bus.cmp_valid) begin
            res_class_r <= bus.cmp_q;
            res_valid_r <= 1'b1;
            load_r      <= 1'b0;
            state_r     <= ST_HOLD;
          end else if (wait_r == WAIT_LAST) begin
            res_class_r <= 4'hF;
            res_valid_r <= 1'b1;
            err_r       <= 1'b1;
            load_r      <= 1'b0;
            state_r     <= ST_HOLD;
          end else begin
            wait_r <= wait_r + WAIT_ONE;
          end
        end
        ST_HOLD: begin
          if (res_valid_r && bus.res_ready) begin
            res_valid_r <= 1'b0;
            cnt1_r      <= '0;
            cnt2_r      <= '0;
            state_r     <= ST_GAP;
          end
        end
        ST_GAP: begin
          state_r <= ST_FILL;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r     <= ST_FILL;
          load_r      <= 1'b0;
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          cnt1_r      <= '0;
          cnt2_r      <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.d1        = d1_r;
  assign bus.d2        = d2_r;
  assign bus.load      = load_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res_class = res_class_r;
  assign bus.err       = err_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_comp_driver.sv
// tb_comp_driver
//   Drives comp_driver through directed and randomized runs. A reference
//   model keeps per-bank element arrays and fill counts, and predicts load,
//   result and error behaviour from the protocol rules.
module tb_comp_driver;

  localparam int DATA_LEN = 16;
  localparam int N_ELEM   = 12;
  localparam int WAIT_MAX = 8;
  localparam int BW       = N_ELEM * DATA_LEN;

  logic clk;
  logic rst;

  comp_driver_if #(.DATA_LEN(DATA_LEN), .N_ELEM(N_ELEM)) bus ();

  comp_driver #(.DATA_LEN(DATA_LEN), .N_ELEM(N_ELEM), .WAIT_MAX(WAIT_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  logic [DATA_LEN-1:0] m_mem [2][N_ELEM];
  int                  m_cnt [2];
  logic                m_err;

  task automatic check_val(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_cnt[b] = 0;
      for (int i = 0; i < N_ELEM; i++) m_mem[b][i] = '0;
    end
    m_err = 1'b0;
  endtask

  task automatic check_banks();
    logic [BW-1:0] e1;
    logic [BW-1:0] e2;
    for (int i = 0; i < N_ELEM; i++) begin
      e1[i*DATA_LEN +: DATA_LEN] = m_mem[0][i];
      e2[i*DATA_LEN +: DATA_LEN] = m_mem[1][i];
    end
    check_val("d1", bus.d1, e1);
    check_val("d2", bus.d2, e2);
  endtask

  // One FILL cycle: offer an element, predict acceptance and the load edge.
  task automatic drive_elem(input logic sel, input logic vld, input logic [DATA_LEN-1:0] data);
    logic exp_rdy;
    logic full;
    bus.in_sel    = sel;
    bus.in_valid  = vld;
    bus.in_data   = data;
    bus.cmp_valid = 1'($urandom_range(0, 1));
    bus.cmp_q     = 4'($urandom);
    #1;
    exp_rdy = (m_cnt[sel] < N_ELEM);
    check_val("in_ready", bus.in_ready, exp_rdy);
    @(posedge clk); #1;
    if (vld && exp_rdy) begin
      m_mem[sel][m_cnt[sel]] = data;
      m_cnt[sel]++;
    end
    bus.in_valid  = 1'b0;
    bus.cmp_valid = 1'b0;
    full = (m_cnt[0] == N_ELEM) && (m_cnt[1] == N_ELEM);
    check_val("fill_load", bus.load, full);
    check_val("fill_busy", bus.busy, full);
    check_banks();
  endtask

  task automatic fill_random();
    int guard;
    guard = 0;
    while (!((m_cnt[0] == N_ELEM) && (m_cnt[1] == N_ELEM)) && guard < 400) begin
      drive_elem(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), DATA_LEN'($urandom));
      guard++;
    end
    if (guard >= 400) check_val("fill_bound", 1'b0, 1'b1);
  endtask

  // RUN: cmp_valid fires on edge resp_at after load rose (never if > WAIT_MAX).
  task automatic run_phase(input int resp_at, input logic [3:0] q, output logic [3:0] cls);
    bit done;
    done = 1'b0;
    cls  = 4'h0;
    for (int k = 1; k <= WAIT_MAX && !done; k++) begin
      bus.in_sel    = 1'($urandom_range(0, 1));
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.res_ready = 1'($urandom_range(0, 1));
      bus.cmp_valid = (k == resp_at);
      bus.cmp_q     = (k == resp_at) ? q : 4'($urandom);
      #1;
      check_val("run_in_ready", bus.in_ready, 1'b0);
      @(posedge clk); #1;
      bus.cmp_valid = 1'b0;
      bus.in_valid  = 1'b0;
      if (k == resp_at) begin
        cls  = q;
        done = 1'b1;
      end else if (k == WAIT_MAX) begin
        cls   = 4'hF;
        m_err = 1'b1;
        done  = 1'b1;
      end
      check_val("run_load", bus.load, !done);
      check_val("run_res_valid", bus.res_valid, done);
      check_val("run_err", bus.err, m_err);
      check_val("run_busy", bus.busy, 1'b1);
      if (done) check_val("run_res_class", bus.res_class, cls);
    end
    check_banks();
  endtask

  // HOLD with stall cycles of backpressure, then GAP, then back to FILL.
  task automatic hold_phase(input int stall, input logic [3:0] cls);
    for (int i = 0; i < stall; i++) begin
      bus.res_ready = 1'b0;
      bus.cmp_valid = 1'($urandom_range(0, 1));
      bus.cmp_q     = 4'($urandom);
      bus.in_valid  = 1'b1;
      bus.in_sel    = 1'($urandom_range(0, 1));
      #1;
      check_val("hold_in_ready", bus.in_ready, 1'b0);
      @(posedge clk); #1;
      check_val("hold_res_valid", bus.res_valid, 1'b1);
      check_val("hold_res_class", bus.res_class, cls);
      check_val("hold_load", bus.load, 1'b0);
      check_val("hold_busy", bus.busy, 1'b1);
    end
    bus.res_ready = 1'b1;
    bus.cmp_valid = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'($urandom_range(0, 1));
    check_val("gap_res_valid", bus.res_valid, 1'b0);
    check_val("gap_load", bus.load, 1'b0);
    check_val("gap_busy", bus.busy, 1'b1);
    check_val("gap_in_ready", bus.in_ready, 1'b0);
    check_val("gap_err", bus.err, m_err);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    check_val("refill_busy", bus.busy, 1'b0);
    check_val("refill_load", bus.load, 1'b0);
    bus.in_sel = 1'b0;
    #1;
    check_val("refill_rdy0", bus.in_ready, 1'b1);
    bus.in_sel = 1'b1;
    #1;
    check_val("refill_rdy1", bus.in_ready, 1'b1);
    check_banks();
  endtask

  initial begin
    logic [3:0] cls;
    logic [3:0] q;
    n_vec = 0;
    n_bad = 0;
    clk = 1'b0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 1'b0;
    bus.in_data   = '0;
    bus.cmp_valid = 1'b0;
    bus.cmp_q     = 4'h0;
    bus.res_ready = 1'b0;
    model_reset();

    // Reset state.
    #3;
    check_val("rst_load", bus.load, 1'b0);
    check_val("rst_res_valid", bus.res_valid, 1'b0);
    check_val("rst_res_class", bus.res_class, 4'h0);
    check_val("rst_err", bus.err, 1'b0);
    check_val("rst_busy", bus.busy, 1'b0);
    check_banks();
    @(posedge clk); #1;
    rst = 1'b0;

    // Normal run: d1 = 10..120, d2 = 0, result 11 on the 6th edge.
    for (int i = 0; i < N_ELEM; i++) drive_elem(1'b0, 1'b1, DATA_LEN'((i + 1) * 10));
    for (int i = 0; i < N_ELEM; i++) drive_elem(1'b1, 1'b1, '0);
    run_phase(6, 4'd11, cls);
    check_val("t1_d1_e11", bus.d1[176 +: 16], 16'd120);
    hold_phase(0, cls);

    // Interleaved fill, then 5 cycles of result backpressure.
    for (int i = 0; i < 2 * N_ELEM; i++) drive_elem(1'(i % 2), 1'b1, DATA_LEN'($urandom));
    q = 4'($urandom);
    run_phase(6, q, cls);
    hold_phase(5, cls);

    // Overflow attempts into a full d1, then d2 fill.
    for (int i = 0; i < N_ELEM; i++) drive_elem(1'b0, 1'b1, DATA_LEN'($urandom));
    for (int i = 0; i < 3; i++) drive_elem(1'b0, 1'b1, DATA_LEN'($urandom));
    for (int i = 0; i < N_ELEM; i++) drive_elem(1'b1, 1'b1, DATA_LEN'($urandom));
    q = 4'($urandom);
    run_phase(6, q, cls);
    hold_phase(2, cls);

    // Timeout, then a normal run with err still set.
    fill_random();
    run_phase(WAIT_MAX + 1, 4'h0, cls);
    hold_phase(1, cls);
    fill_random();
    q = 4'($urandom);
    run_phase(6, q, cls);
    hold_phase(0, cls);

    // Reset during the 3rd load-high cycle, then a full refill.
    fill_random();
    for (int k = 1; k <= 2; k++) begin
      bus.cmp_valid = 1'b0;
      @(posedge clk); #1;
      check_val("pre_rst_load", bus.load, 1'b1);
    end
    rst = 1'b1;
    #1;
    model_reset();
    check_val("mid_rst_load", bus.load, 1'b0);
    check_val("mid_rst_res_valid", bus.res_valid, 1'b0);
    check_val("mid_rst_res_class", bus.res_class, 4'h0);
    check_val("mid_rst_err", bus.err, 1'b0);
    check_val("mid_rst_busy", bus.busy, 1'b0);
    check_banks();
    @(posedge clk); #1;
    rst = 1'b0;
    fill_random();
    q = 4'($urandom);
    run_phase(6, q, cls);
    hold_phase(3, cls);

    // Random runs with random response latency (including timeouts).
    for (int r = 0; r < 6; r++) begin
      fill_random();
      q = 4'($urandom);
      run_phase($urandom_range(1, WAIT_MAX + 1), q, cls);
      hold_phase($urandom_range(0, 4), cls);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
